hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: REG_AW, 5, register-address width; LOAD_LAT, 1, load-use stall cycles (1..7); BR_LAT, 2, branch-vs-IDEX-producer stall cycles (1..7); PCSRC_W, 3, pcsrc width; BR_CODE_A, 3'b001, branch pcsrc code; BR_CODE_B, 3'b011, jump-register pcsrc code.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- idex_memread, idex_regwr, idex_jump  in  1 each  ID/EX load, register-write and jump flags.
- idex_rt, idex_rd  in  REG_AW each  ID/EX load target and ALU destination.
- exmem_regwr  in  1  EX/MEM register-write flag.
- exmem_rd  in  REG_AW  EX/MEM destination.
- ifid_rs, ifid_rt  in  REG_AW each  IF/ID source registers.
- ifid_memwr  in  1  IF/ID store flag.
- ifid_pcsrc  in  PCSRC_W  IF/ID PC-source code.
- stall  out  1  hold PC and IF/ID.
- pc_write  out  1  PC write enable.
- ifid_write  out  1  IF/ID write enable.
- id_flush  out  1  bubble into ID/EX.
- if_flush  out  1  clear IF/ID.
- busy  out  1  multi-cycle stall in progress.

Function
REQ-003 SHALL implement FSM states RUN, LD_STALL and BR_STALL, with a 3-bit remaining-cycle counter cnt.
REQ-004 Load-use hazard (RUN only) SHALL be: idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (idex_rt==ifid_rt && !ifid_memwr)).
REQ-005 Branch dependency SHALL apply only when ifid_pcsrc equals BR_CODE_A or BR_CODE_B, with src = ifid_rs or ifid_rt.
- EX match: idex_regwr && idex_rd!=0 && idex_rd==src.
- MEM match: exmem_regwr && exmem_rd!=0 && exmem_rd==src.
REQ-006 Register 0 SHALL never create a hazard.
REQ-007 Priority in RUN SHALL be: idex_jump > load-use > branch EX match > branch MEM match.
REQ-008 idex_jump in RUN SHALL assert if_flush=1 and stall=0 in the same cycle, combinationally, for exactly 1 cycle per jump, with no state change.
REQ-009 Load-use detect SHALL assert stall in the same cycle; if LOAD_LAT>1 the next state SHALL be LD_STALL with cnt<=LOAD_LAT-1, else the FSM SHALL stay in RUN.
REQ-010 Branch EX match SHALL behave as REQ-009 with BR_LAT and state BR_STALL.
REQ-011 Branch MEM match SHALL give exactly 1 stall cycle and the FSM SHALL stay in RUN.
REQ-012 In LD_STALL and BR_STALL, stall SHALL be 1 and cnt<=cnt-1; when cnt==1 the next state SHALL be RUN.
REQ-013 Total stall cycles SHALL equal LOAD_LAT or BR_LAT exactly.
REQ-014 Hazard detection and idex_jump SHALL be ignored in non-RUN states, since ID/EX holds bubbles there.
REQ-015 After return to RUN, hazards SHALL be re-evaluated on the first RUN cycle.
REQ-016 Output relations in all states:
- pc_write = ifid_write = ~stall.
- id_flush = stall.
- busy = (state!=RUN).
- stall and if_flush SHALL never both be 1.
REQ-017 cnt SHALL never underflow; parameter values of 0 or >7 SHALL be a compile-time error.

Reset
REQ-018 Asserting reset (low) SHALL force the following immediately, regardless of clk and inputs, including mid-stall:
- state=RUN, cnt=0.
- stall=0, id_flush=0, if_flush=0, busy=0.
- pc_write=1, ifid_write=1.
REQ-019 On the first rising clk after reset deasserts, normal detection SHALL apply.

Configuration
REQ-020 Macro HAZARD_PERF_CNT_EN SHALL control the performance counters.
- When defined: add ports perf_clr (in, 1, synchronous clear), stall_cycles (out, 32) and flush_events (out, 32).
- stall_cycles SHALL increment on each cycle with stall=1.
- flush_events SHALL increment on each cycle with if_flush=1.
- Both counters SHALL saturate at 32'hFFFF_FFFF.
- perf_clr SHALL win over an increment in the same cycle.
- Both counters SHALL reset to 0.
- When undefined: these ports and registers SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-021 Load-use, LOAD_LAT=3: idex_memread=1, idex_rt=5, ifid_rs=5 -> stall=1 for exactly 3 cycles, busy=1 for the last 2, pc_write=0 throughout, then RUN.
REQ-022 Store exemption: idex_memread=1, idex_rt=7, ifid_rt=7, ifid_memwr=1, ifid_rs=2 -> stall=0.
REQ-023 $0 exemption: idex_memread=1, idex_rt=0, ifid_rs=0 -> stall=0.
REQ-024 Branch dependencies, BR_LAT=2, ifid_pcsrc=3'b001, ifid_rs=9:
- idex_regwr=1, idex_rd=9 -> 2 stall cycles.
- Only exmem_regwr=1, exmem_rd=9 -> 1 stall cycle.
REQ-025 Simultaneous jump and load-use -> if_flush=1, stall=0 for 1 cycle; jump during BR_STALL -> ignored.
REQ-026 Reset pulled low during cycle 2 of a 3-cycle LD_STALL -> immediately stall=0, busy=0, pc_write=1; with HAZARD_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-dependency stalls, jump flush.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int                 REG_AW    = 5,
    parameter int                 LOAD_LAT  = 1,
    parameter int                 BR_LAT    = 2,
    parameter int                 PCSRC_W   = 3,
    parameter logic [PCSRC_W-1:0] BR_CODE_A = 3'b001,
    parameter logic [PCSRC_W-1:0] BR_CODE_B = 3'b011
) (
    input  logic               clk,
    input  logic               reset,
`ifdef HAZARD_PERF_CNT_EN
    input  logic               perf_clr,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_events,
`endif
    input  logic               idex_memread,
    input  logic               idex_regwr,
    input  logic               idex_jump,
    input  logic [REG_AW-1:0]  idex_rt,
    input  logic [REG_AW-1:0]  idex_rd,
    input  logic               exmem_regwr,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic [REG_AW-1:0]  ifid_rs,
    input  logic [REG_AW-1:0]  ifid_rt,
    input  logic               ifid_memwr,
    input  logic [PCSRC_W-1:0] ifid_pcsrc,
    output logic               stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               id_flush,
    output logic               if_flush,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT must be in 1..7");
    end
    if (BR_LAT < 1 || BR_LAT > 7) begin : g_bad_br_lat
        $error("hazard_ctrl: BR_LAT must be in 1..7");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_STALL = 2'd2
    } state_t;

    localparam logic [2:0] LOAD_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_INIT   = 3'(BR_LAT - 1);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       stall_raw, flush_raw;
    logic       lu_hit, is_br, ex_hit, mem_hit;

    assign lu_hit  = idex_memread && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || ((idex_rt == ifid_rt) && !ifid_memwr));
    assign is_br   = (ifid_pcsrc == BR_CODE_A) || (ifid_pcsrc == BR_CODE_B);
    assign ex_hit  = is_br && idex_regwr && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    assign mem_hit = is_br && exmem_regwr && (exmem_rd != '0) &&
                     ((exmem_rd == ifid_rs) || (exmem_rd == ifid_rt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The RUN cycle that detects a hazard is itself the first stall cycle,
    // so the counter is loaded with LAT-1 remaining cycles.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall_raw = 1'b0;
        flush_raw = 1'b0;
        case (state)
            RUN: begin
                if (idex_jump) begin
                    flush_raw = 1'b1;
                end else if (lu_hit) begin
                    stall_raw = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_n = LD_STALL;
                        cnt_n   = LOAD_INIT;
                    end
                end else if (ex_hit) begin
                    stall_raw = 1'b1;
                    if (BR_LAT > 1) begin
                        state_n = BR_STALL;
                        cnt_n   = BR_INIT;
                    end
                end else if (mem_hit) begin
                    stall_raw = 1'b1;
                end
            end
            LD_STALL, BR_STALL: begin
                stall_raw = 1'b1;
                if (cnt <= 3'd1) begin
                    state_n = RUN;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = 3'd0;
            end
        endcase
    end

    // Gating with reset keeps the outputs quiet while reset is held low,
    // even though detection itself is combinational on the inputs.
    assign stall      = stall_raw & reset;
    assign if_flush   = flush_raw & reset;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign id_flush   = stall;
    assign busy       = (state != RUN);
    assign state_dbg  = state;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else if (perf_clr) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + 32'd1;
            if (if_flush && (flush_events != CNT_MAX)) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=3, BR_LAT=2): vector table plus
// multi-cycle sequences for stall length, ignored jumps, re-evaluation and reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       idex_memread, idex_regwr, idex_jump;
    logic [4:0] idex_rt, idex_rd;
    logic       exmem_regwr;
    logic [4:0] exmem_rd, ifid_rs, ifid_rt;
    logic       ifid_memwr;
    logic [2:0] ifid_pcsrc;
    logic       stall, pc_write, ifid_write, id_flush, if_flush, busy;
    logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] stall_cycles, flush_events;
`endif

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .REG_AW(5), .LOAD_LAT(3), .BR_LAT(2), .PCSRC_W(3),
        .BR_CODE_A(3'b001), .BR_CODE_B(3'b011)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clr(perf_clr),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
`endif
        .idex_memread(idex_memread),
        .idex_regwr(idex_regwr),
        .idex_jump(idex_jump),
        .idex_rt(idex_rt),
        .idex_rd(idex_rd),
        .exmem_regwr(exmem_regwr),
        .exmem_rd(exmem_rd),
        .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt),
        .ifid_memwr(ifid_memwr),
        .ifid_pcsrc(ifid_pcsrc),
        .stall(stall),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .id_flush(id_flush),
        .if_flush(if_flush),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       memread, regwr, jump;
        logic [4:0] idex_rt, idex_rd;
        logic       exmem_regwr;
        logic [4:0] exmem_rd, rs, rt;
        logic       memwr;
        logic [2:0] pcsrc;
        logic       exp_stall, exp_flush, exp_busy_next;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic mr, input logic rw, input logic jp,
                                input logic [4:0] xrt, input logic [4:0] xrd,
                                input logic mw_rw, input logic [4:0] mrd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic st, input logic [2:0] pc,
                                input logic es, input logic ef, input logic eb);
        vec_t v;
        v.memread = mr; v.regwr = rw; v.jump = jp;
        v.idex_rt = xrt; v.idex_rd = xrd;
        v.exmem_regwr = mw_rw; v.exmem_rd = mrd;
        v.rs = rs; v.rt = rt; v.memwr = st; v.pcsrc = pc;
        v.exp_stall = es; v.exp_flush = ef; v.exp_busy_next = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic es, input logic ef, input logic eb);
        check({name, ".stall"},      {31'd0, stall},      {31'd0, es});
        check({name, ".if_flush"},   {31'd0, if_flush},   {31'd0, ef});
        check({name, ".pc_write"},   {31'd0, pc_write},   {31'd0, ~es});
        check({name, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, ~es});
        check({name, ".id_flush"},   {31'd0, id_flush},   {31'd0, es});
        check({name, ".busy"},       {31'd0, busy},       {31'd0, eb});
    endtask

    task automatic set_idle();
        idex_memread = 0; idex_regwr = 0; idex_jump = 0;
        idex_rt = 0; idex_rd = 0; exmem_regwr = 0; exmem_rd = 0;
        ifid_rs = 0; ifid_rt = 0; ifid_memwr = 0; ifid_pcsrc = 3'b000;
    endtask

    task automatic drive(input vec_t v);
        idex_memread = v.memread; idex_regwr = v.regwr; idex_jump = v.jump;
        idex_rt = v.idex_rt; idex_rd = v.idex_rd;
        exmem_regwr = v.exmem_regwr; exmem_rd = v.exmem_rd;
        ifid_rs = v.rs; ifid_rt = v.rt; ifid_memwr = v.memwr; ifid_pcsrc = v.pcsrc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 12 && busy; k++) @(negedge clk);
        check({name, ".drain_busy"}, {31'd0, busy}, 32'd0);
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic perf_clear();
        next_cycle();
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
    endtask
`endif

    initial begin
        //          mr rw jp xrt xrd mrw mrd rs  rt  st pc       st fl bn
        vecs[0]  = mk(0, 0, 0, 0,  0,  0,  0,  0,  0,  0, 3'b000, 0, 0, 0); // idle
        vecs[1]  = mk(1, 0, 0, 5,  0,  0,  0,  5,  0,  0, 3'b000, 1, 0, 1); // load-use on rs
        vecs[2]  = mk(1, 0, 0, 6,  0,  0,  0,  1,  6,  0, 3'b000, 1, 0, 1); // load-use on rt
        vecs[3]  = mk(1, 0, 0, 7,  0,  0,  0,  2,  7,  1, 3'b000, 0, 0, 0); // store exemption
        vecs[4]  = mk(1, 0, 0, 0,  0,  0,  0,  0,  0,  0, 3'b000, 0, 0, 0); // $0 load
        vecs[5]  = mk(0, 1, 0, 0,  9,  0,  0,  9,  0,  0, 3'b001, 1, 0, 1); // branch EX match
        vecs[6]  = mk(0, 0, 0, 0,  0,  1,  9,  9,  0,  0, 3'b001, 1, 0, 0); // branch MEM match
        vecs[7]  = mk(0, 1, 0, 0, 12,  0,  0,  1, 12,  0, 3'b011, 1, 0, 1); // jr EX match on rt
        vecs[8]  = mk(0, 1, 0, 0,  9,  0,  0,  9,  0,  0, 3'b010, 0, 0, 0); // non-branch code
        vecs[9]  = mk(0, 1, 0, 0,  0,  0,  0,  0,  0,  0, 3'b001, 0, 0, 0); // branch on $0
        vecs[10] = mk(1, 0, 1, 5,  0,  0,  0,  5,  0,  0, 3'b000, 0, 1, 0); // jump beats load-use
        vecs[11] = mk(0, 0, 1, 0,  0,  0,  0,  0,  0,  0, 3'b000, 0, 1, 0); // jump alone
        vecs[12] = mk(0, 1, 0, 0,  9,  1,  9,  9,  0,  0, 3'b001, 1, 0, 1); // EX beats MEM
        vecs[13] = mk(0, 0, 0, 0,  0,  1,  0,  0,  0,  0, 3'b011, 0, 0, 0); // MEM on $0
        vecs[14] = mk(1, 0, 0, 4,  0,  0,  0,  3,  8,  0, 3'b000, 0, 0, 0); // load, no match
        vecs[15] = mk(0, 0, 0, 0,  0,  1, 14,  2, 14,  0, 3'b011, 1, 0, 0); // jr MEM on rt

        // Reset held low with hazardous inputs: outputs must stay quiet.
        set_idle();
        idex_memread = 1; idex_rt = 5; ifid_rs = 5; idex_jump = 1;
        #3;
        check_outs("reset", 0, 0, 0);
        check("reset.state", {30'd0, state_dbg}, 32'd0);
        idex_jump = 0;
        #1;
        check_outs("reset_lu", 0, 0, 0);
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("post_reset", 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset.stall_cycles", stall_cycles, 32'd0);
        check("reset.flush_events", flush_events, 32'd0);
`endif

        // Table: one cycle of inputs, then idle until the FSM is back in RUN.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            drive(vecs[i]);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush, 1'b0);
            next_cycle();
            set_idle();
            @(negedge clk);
            check($sformatf("vec%0d.busy_next", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy_next});
            drain($sformatf("vec%0d", i));
        end

        // Load-use with LOAD_LAT=3: three stall cycles, busy on the last two.
`ifdef HAZARD_PERF_CNT_EN
        perf_clear();
`endif
        next_cycle();
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        @(negedge clk); check_outs("lu_c1", 1, 0, 0);
        next_cycle(); set_idle();
        @(negedge clk); check_outs("lu_c2", 1, 0, 1);
        @(negedge clk); check_outs("lu_c3", 1, 0, 1);
        @(negedge clk); check_outs("lu_c4", 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        check("lu.stall_cycles", stall_cycles, 32'd3);
        perf_clear();
`endif

        // Branch EX stall; a jump arriving during BR_STALL is ignored.
        next_cycle();
        ifid_pcsrc = 3'b001; ifid_rs = 9; idex_regwr = 1; idex_rd = 9;
        @(negedge clk); check_outs("br_c1", 1, 0, 0);
        next_cycle(); set_idle(); idex_jump = 1;
        @(negedge clk); check_outs("br_c2_jump_ignored", 1, 0, 1);
        @(negedge clk); check_outs("br_c3_jump_taken", 0, 1, 0);
        next_cycle(); set_idle();
        @(negedge clk); check_outs("br_c4", 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        check("br.stall_cycles", stall_cycles, 32'd2);
        check("br.flush_events", flush_events, 32'd1);
`endif

        // Load-use outranks branch EX match: stall lasts LOAD_LAT, not BR_LAT.
        next_cycle();
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        ifid_pcsrc = 3'b001; idex_regwr = 1; idex_rd = 5;
        @(negedge clk); check_outs("prio_c1", 1, 0, 0);
        next_cycle(); set_idle();
        @(negedge clk); check_outs("prio_c2", 1, 0, 1);
        @(negedge clk); check_outs("prio_c3", 1, 0, 1);
        @(negedge clk); check_outs("prio_c4", 0, 0, 0);

        // Hazard held: detection restarts on the first cycle back in RUN.
        next_cycle();
        idex_memread = 1; idex_rt = 6; ifid_rt = 6;
        @(negedge clk); check_outs("reeval_c1", 1, 0, 0);
        @(negedge clk); check_outs("reeval_c2", 1, 0, 1);
        @(negedge clk); check_outs("reeval_c3", 1, 0, 1);
        @(negedge clk); check_outs("reeval_c4", 1, 0, 0);
        next_cycle(); set_idle();
        drain("reeval");

        // Reset asserted in the middle of the second LD_STALL cycle.
`ifdef HAZARD_PERF_CNT_EN
        perf_clear();
`endif
        next_cycle();
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        @(negedge clk); check_outs("rst_mid_c1", 1, 0, 0);
        next_cycle();
        #2 reset = 1'b0;
        #1;
        check_outs("rst_mid", 0, 0, 0);
        check("rst_mid.state", {30'd0, state_dbg}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst_mid.stall_cycles", stall_cycles, 32'd0);
`endif
        idex_jump = 1;
        #1;
        check("rst_mid.if_flush", {31'd0, if_flush}, 32'd0);
        idex_jump = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("rst_release", 1, 0, 0);
        @(negedge clk); check_outs("rst_release_c2", 1, 0, 1);
        next_cycle(); set_idle();
        drain("rst_release");

`ifdef HAZARD_PERF_CNT_EN
        // perf_clr wins over a flush increment in the same cycle.
        perf_clear();
        next_cycle();
        idex_jump = 1; perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        next_cycle();
        idex_jump = 0;
        @(negedge clk);
        check("perf_clr_wins.flush_events", flush_events, 32'd1);
        check("perf_clr_wins.stall_cycles", stall_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
